// File: rtl/vedic_pkg.sv
// Shared widths and sign helpers for the pipelined Urdhva-Tiryagbhyam multiplier.
// The helpers work on a fixed maximum width; callers size-cast to their own WIDTH.
package vedic_pkg;

  localparam int VEDIC_WIDTH = 8;
  localparam int VEDIC_TAG_W = 4;
  localparam int VEDIC_HALF  = VEDIC_WIDTH / 2;
  localparam int MAX_W       = 32;

  typedef logic [MAX_W-1:0]   mag_t;
  typedef logic [2*MAX_W-1:0] wide_t;

  // Magnitude of a w-bit operand; the most negative value maps to 2^(w-1) without overflow.
  function automatic mag_t abs_mag(input mag_t x, input int w, input logic sgn);
    mag_t mask;
    mag_t sh;
    mask = (mag_t'(1) << w) - mag_t'(1);
    sh   = x >> (w - 1);
    if (sgn && sh[0]) return (~x + mag_t'(1)) & mask;
    else              return x & mask;
  endfunction

  function automatic wide_t twos_neg(input wide_t x);
    return ~x + wide_t'(1);
  endfunction

endpackage

// File: rtl/vedic_mult_comb.sv
// Combinational N x N unsigned Urdhva multiplier, recursing down to a 2x2 half-adder cell.
module vedic_mult_comb #(
  parameter int N = 4
) (
  input  logic [N-1:0]   a_i,
  input  logic [N-1:0]   b_i,
  output logic [2*N-1:0] p_o
);

  if (N == 2) begin : g_base
    logic pp00, pp01, pp10, pp11, c1;
    assign pp00 = a_i[0] & b_i[0];
    assign pp01 = a_i[0] & b_i[1];
    assign pp10 = a_i[1] & b_i[0];
    assign pp11 = a_i[1] & b_i[1];
    assign p_o[0] = pp00;
    assign p_o[1] = pp10 ^ pp01;
    assign c1     = pp10 & pp01;
    assign p_o[2] = pp11 ^ c1;
    assign p_o[3] = pp11 & c1;
  end else begin : g_rec
    localparam int H = N / 2;
    logic [N-1:0] ll, lh, hl, hh;
    logic [N:0]   mid;

    vedic_mult_comb #(.N(H)) u_ll (.a_i(a_i[H-1:0]), .b_i(b_i[H-1:0]), .p_o(ll));
    vedic_mult_comb #(.N(H)) u_lh (.a_i(a_i[H-1:0]), .b_i(b_i[N-1:H]), .p_o(lh));
    vedic_mult_comb #(.N(H)) u_hl (.a_i(a_i[N-1:H]), .b_i(b_i[H-1:0]), .p_o(hl));
    vedic_mult_comb #(.N(H)) u_hh (.a_i(a_i[N-1:H]), .b_i(b_i[N-1:H]), .p_o(hh));

    // Crosswise terms are summed once, then placed at weight 2^H over the vertical terms.
    assign mid = {1'b0, lh} + {1'b0, hl};
    assign p_o = {hh, ll} + {{(H-1){1'b0}}, mid, {H{1'b0}}};
  end

endmodule

// File: rtl/vedic_mult_pipe.sv
// Three-stage signed/unsigned Vedic multiplier with valid/ready handshake and a pass-through tag.
// The whole pipeline stalls as one unit whenever the output is held.
module vedic_mult_pipe
  import vedic_pkg::*;
#(
  parameter int WIDTH = VEDIC_WIDTH,
  parameter int TAG_W = VEDIC_TAG_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_signed,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int HALF = WIDTH / 2;
  localparam int PW   = 2 * WIDTH;

  logic en;
  logic vld_p1_q, vld_p2_q, vld_p3_q;

  logic [WIDTH-1:0] mag_a_d, mag_b_d, mag_a_p1_q, mag_b_p1_q;
  logic             neg_d, neg_p1_q, neg_p2_q;
  logic [TAG_W-1:0] tag_p1_q, tag_p2_q, out_tag_q;

  logic [WIDTH-1:0] ll_d, lh_d, hl_d, hh_d;
  logic [WIDTH-1:0] ll_p2_q, lh_p2_q, hl_p2_q, hh_p2_q;

  logic [PW-1:0] prod_d, out_p_d, out_p_q;

  assign en       = ~vld_p3_q | out_ready;
  assign in_ready = en;

  // S1: sign-magnitude split of the incoming operands
  assign mag_a_d = WIDTH'(abs_mag(MAX_W'(in_a), WIDTH, in_signed));
  assign mag_b_d = WIDTH'(abs_mag(MAX_W'(in_b), WIDTH, in_signed));
  assign neg_d   = in_signed & (in_a[WIDTH-1] ^ in_b[WIDTH-1]);

  // S2: four half-width partial products
  vedic_mult_comb #(.N(HALF)) u_ll (.a_i(mag_a_p1_q[HALF-1:0]),     .b_i(mag_b_p1_q[HALF-1:0]),     .p_o(ll_d));
  vedic_mult_comb #(.N(HALF)) u_lh (.a_i(mag_a_p1_q[HALF-1:0]),     .b_i(mag_b_p1_q[WIDTH-1:HALF]), .p_o(lh_d));
  vedic_mult_comb #(.N(HALF)) u_hl (.a_i(mag_a_p1_q[WIDTH-1:HALF]), .b_i(mag_b_p1_q[HALF-1:0]),     .p_o(hl_d));
  vedic_mult_comb #(.N(HALF)) u_hh (.a_i(mag_a_p1_q[WIDTH-1:HALF]), .b_i(mag_b_p1_q[WIDTH-1:HALF]), .p_o(hh_d));

  // S3: recombine at 2*WIDTH+1 bits, then restore the sign
  assign prod_d  = PW'((PW+1)'({hh_p2_q, ll_p2_q})
                     + ((PW+1)'(lh_p2_q) << HALF)
                     + ((PW+1)'(hl_p2_q) << HALF));
  assign out_p_d = neg_p2_q ? PW'(twos_neg(wide_t'(prod_d))) : prod_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1_q  <= 1'b0;
      vld_p2_q  <= 1'b0;
      vld_p3_q  <= 1'b0;
      out_p_q   <= '0;
      out_tag_q <= '0;
    end else if (en) begin
      vld_p1_q  <= in_valid;
      vld_p2_q  <= vld_p1_q;
      vld_p3_q  <= vld_p2_q;
      out_p_q   <= out_p_d;
      out_tag_q <= tag_p2_q;
    end
  end

  // Inner data stages carry no reset: their contents are qualified by the valid bits.
  always_ff @(posedge clk) begin
    if (en && in_valid) begin
      mag_a_p1_q <= mag_a_d;
      mag_b_p1_q <= mag_b_d;
      neg_p1_q   <= neg_d;
      tag_p1_q   <= in_tag;
    end
    if (en) begin
      ll_p2_q  <= ll_d;
      lh_p2_q  <= lh_d;
      hl_p2_q  <= hl_d;
      hh_p2_q  <= hh_d;
      neg_p2_q <= neg_p1_q;
      tag_p2_q <= tag_p1_q;
    end
  end

  assign out_valid = vld_p3_q;
  assign out_p     = out_p_q;
  assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_vedic_mult_pipe.sv
// Directed-vector and scoreboard bench for vedic_mult_pipe at WIDTH=8, TAG_W=4.
`timescale 1ns/1ps
module tb_vedic_mult_pipe;

  localparam int W  = 8;
  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, in_signed;
  logic [W-1:0]  in_a, in_b;
  logic [TW-1:0] in_tag;
  logic          out_valid, out_ready;
  logic [2*W-1:0] out_p;
  logic [TW-1:0] out_tag;

  always #5 clk = ~clk;

  vedic_mult_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_signed(in_signed),
    .in_tag   (in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_p    (out_p),
    .out_tag  (out_tag)
  );

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           s;
    logic [TW-1:0]  tag;
    logic [2*W-1:0] p;
  } vec_t;

  typedef struct {
    logic [2*W-1:0] p;
    logic [TW-1:0]  tag;
  } exp_t;

  vec_t vecs[7];
  exp_t sbq[$];
  logic sb_en = 1'b0;
  int   checks = 0;
  int   fails  = 0;
  int   sb_push = 0;
  int   sb_pop  = 0;

  function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic s);
    logic signed [2*W-1:0] rs;
    logic [2*W-1:0]        ru;
    rs = 16'($signed(a)) * 16'($signed(b));
    ru = 16'(a) * 16'(b);
    return s ? rs : ru;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       input logic [TW-1:0] tag);
    in_valid  = 1'b1;
    in_a      = a;
    in_b      = b;
    in_signed = s;
    in_tag    = tag;
  endtask

  // Transfers are judged at the falling edge, i.e. the values the next rising edge will see.
  always @(negedge clk) begin
    exp_t e;
    if (sb_en && rst_n) begin
      if (in_valid && in_ready) begin
        sbq.push_back('{model(in_a, in_b, in_signed), in_tag});
        sb_push++;
      end
      if (out_valid && out_ready) begin
        sb_pop++;
        if (sbq.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL sb_extra: unexpected result p=%0h tag=%0h at %0t", out_p, out_tag, $time);
        end else begin
          e = sbq.pop_front();
          check("sb_p", 64'(out_p), 64'(e.p));
          check("sb_tag", 64'(out_tag), 64'(e.tag));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int vcount;
    int cyc;
    int pushed0;
    logic acc;
    logic [2*W-1:0] hold_p;
    logic [TW-1:0]  hold_tag;

    vecs[0] = '{8'd255, 8'd255, 1'b0, 4'd3, 16'hFE01};
    vecs[1] = '{8'd0,   8'd200, 1'b0, 4'd1, 16'h0000};
    vecs[2] = '{8'h80,  8'h80,  1'b1, 4'd4, 16'h4000};
    vecs[3] = '{8'hFF,  8'h7F,  1'b1, 4'd5, 16'hFF81};
    vecs[4] = '{8'h7F,  8'h80,  1'b1, 4'd6, 16'hC080};
    vecs[5] = '{8'h80,  8'h80,  1'b0, 4'd7, 16'h4000};
    vecs[6] = '{8'hFF,  8'h7F,  1'b0, 4'd8, 16'h7E81};

    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_signed = 1'b0; in_tag = '0;
    out_ready = 1'b1;

    #12;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_p", 64'(out_p), 64'd0);
    check("rst_out_tag", 64'(out_tag), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("rst_in_ready", 64'(in_ready), 64'd1);

    // Unsigned corners one at a time, checking exact latency.
    for (int i = 0; i < 2; i++) begin
      drive(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].tag);
      tick();
      in_valid = 1'b0;
      check("lat_early", 64'(out_valid), 64'd0);
      tick();
      check("lat_early2", 64'(out_valid), 64'd0);
      tick();
      check("lat_valid", 64'(out_valid), 64'd1);
      check("vec_p", 64'(out_p), 64'(vecs[i].p));
      check("vec_tag", 64'(out_tag), 64'(vecs[i].tag));
      tick();
      check("vec_no_dup", 64'(out_valid), 64'd0);
    end

    // Signed and same-pattern unsigned corners, back to back.
    for (int j = 0; j < 7; j++) begin
      if (j < 5) drive(vecs[j+2].a, vecs[j+2].b, vecs[j+2].s, vecs[j+2].tag);
      else       in_valid = 1'b0;
      tick();
      if (j >= 2) begin
        check("b2b_valid", 64'(out_valid), 64'd1);
        check("b2b_p", 64'(out_p), 64'(vecs[j].p));
        check("b2b_tag", 64'(out_tag), 64'(vecs[j].tag));
      end
    end
    tick();
    check("b2b_drained", 64'(out_valid), 64'd0);

    // Throughput: 16 ops on consecutive cycles.
    sb_en  = 1'b1;
    vcount = 0;
    for (int j = 0; j < 18; j++) begin
      if (j < 16) drive(8'($urandom), 8'($urandom), 1'($urandom), 4'(j));
      else        in_valid = 1'b0;
      tick();
      if (j == 1) check("tp_not_early", 64'(out_valid), 64'd0);
      if (j >= 2 && out_valid) vcount++;
    end
    check("tp_count", 64'(vcount), 64'd16);
    for (int k = 0; k < 4; k++) tick();
    check("tp_queue_empty", 64'(sbq.size()), 64'd0);

    // Backpressure: 4 accepted, then sink holds for 5 cycles.
    for (int j = 0; j < 4; j++) begin
      drive(8'($urandom), 8'($urandom), 1'($urandom), 4'(j + 9));
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    hold_p    = out_p;
    hold_tag  = out_tag;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("bp_valid", 64'(out_valid), 64'd1);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_p_stable", 64'(out_p), 64'(hold_p));
      check("bp_tag_stable", 64'(out_tag), 64'(hold_tag));
    end
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) tick();
    check("bp_queue_empty", 64'(sbq.size()), 64'd0);
    check("bp_drained", 64'(out_valid), 64'd0);

    // Random sink backpressure over 1000 ops.
    pushed0 = sb_push;
    cyc = 0;
    for (int n = 0; n < 1000 && cyc < 20000; ) begin
      drive(8'($urandom), 8'($urandom), 1'($urandom), 4'($urandom));
      acc = 1'b0;
      while (!acc && cyc < 20000) begin
        out_ready = 1'($urandom);
        #1;
        acc = in_ready;
        tick();
        cyc++;
      end
      if (acc) n++;
    end
    check("rand_budget", 64'(cyc < 20000), 64'd1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 20 && sbq.size() != 0; k++) tick();
    tick();
    check("rand_accepted", 64'(sb_push - pushed0), 64'd1000);
    check("rand_queue_empty", 64'(sbq.size()), 64'd0);
    check("rand_push_pop", 64'(sb_pop), 64'(sb_push));
    check("rand_no_extra", 64'(out_valid), 64'd0);

    // Asynchronous reset with three ops in flight.
    sb_en = 1'b0;
    for (int j = 0; j < 3; j++) begin
      drive(vecs[j+2].a, vecs[j+2].b, vecs[j+2].s, vecs[j+2].tag);
      tick();
    end
    in_valid = 1'b0;
    check("rst_pre_valid", 64'(out_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_valid", 64'(out_valid), 64'd0);
    check("rst_async_p", 64'(out_p), 64'd0);
    check("rst_async_tag", 64'(out_tag), 64'd0);
    tick();
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("rst_post_ready", 64'(in_ready), 64'd1);
    check("rst_post_valid", 64'(out_valid), 64'd0);
    drive(8'd7, 8'd9, 1'b0, 4'd5);
    tick();
    in_valid = 1'b0;
    check("rst_new_early", 64'(out_valid), 64'd0);
    tick();
    check("rst_new_early2", 64'(out_valid), 64'd0);
    tick();
    check("rst_new_valid", 64'(out_valid), 64'd1);
    check("rst_new_p", 64'(out_p), 64'd63);
    check("rst_new_tag", 64'(out_tag), 64'd5);
    tick();
    check("rst_new_no_dup", 64'(out_valid), 64'd0);
    tick();
    check("rst_old_gone", 64'(out_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
